// File: rtl/store_pkg.sv
// Shared definitions for the store narrowing path: size encodings, FSM states
// and the byte-count mask helper.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } state_e;

  // Low-aligned byte mask for a store size; the illegal size maps to no bytes.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// Request and memory-write handshake bundle for store_narrow_unit.
// The slave modport is the unit's view; master is the surrounding pipeline/memory.
interface store_narrow_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              err;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, err, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, err, busy
  );
endinterface

// File: rtl/store_lane_align.sv
// Places the low 1/2/4 bytes of a store on little-endian byte lanes. The
// shifted value spans two words; beat_sel picks the low (first) or high word.
module store_lane_align
  import store_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        beat_sel,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        split
);

  logic [3:0]  mask;
  logic [31:0] lane_keep;
  logic [7:0]  be_wide;
  logic [63:0] data_wide;

  always_comb begin
    mask      = size_mask(size);
    // Bytes above the store size are cleared so unused lanes carry zero.
    lane_keep = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    be_wide   = {4'b0000, mask} << offset;
    data_wide = {32'h0, data & lane_keep} << {offset, 3'b000};
    split     = |be_wide[7:4];
    wdata     = beat_sel ? data_wide[63:32] : data_wide[31:0];
    be        = beat_sel ? be_wide[7:4]     : be_wide[3:0];
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: registers a store request, then issues one or two
// word-aligned write beats with lane-placed data and byte enables.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  store_narrow_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              split_q, split_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              req_ready_q, req_ready_d;

  logic              idle;
  logic              accept;
  logic [31:0]       al_wdata;
  logic [3:0]        al_be;
  logic              al_split;

  assign idle   = (state_q == IDLE);
  assign accept = bus.req_valid && req_ready_q;

  // One aligner serves both beats: in IDLE it sees the live request (beat 1),
  // afterwards the captured request (beat 2).
  store_lane_align u_align (
    .data     (idle ? bus.req_data      : data_q),
    .offset   (idle ? bus.req_addr[1:0] : off_q),
    .size     (idle ? bus.req_size      : size_q),
    .beat_sel (!idle),
    .wdata    (al_wdata),
    .be       (al_be),
    .split    (al_split)
  );

  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    data_d      = data_q;
    off_d       = off_q;
    size_d      = size_q;
    split_d     = split_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (size_mask(bus.req_size) == 4'b0000) begin
            err_d = 1'b1;
          end else begin
            state_d     = BEAT1;
            data_d      = bus.req_data;
            off_d       = bus.req_addr[1:0];
            size_d      = bus.req_size;
            split_d     = al_split;
            mem_valid_d = 1'b1;
            mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = al_wdata;
            mem_be_d    = al_be;
          end
        end
      end
      BEAT1: begin
        if (bus.mem_ready) begin
          if (split_q) begin
            state_d     = BEAT2;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_wdata_d = al_wdata;
            mem_be_d    = al_be;
          end else begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
          end
        end
      end
      BEAT2: begin
        if (bus.mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      split_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      off_q       <= off_d;
      size_q      <= size_d;
      split_q     <= split_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Scoreboard bench for store_narrow_unit: directed stores push expected beats,
// a negedge monitor pops and compares every accepted write beat.
module tb_store_narrow_unit;
  import store_pkg::*;

  localparam int ADDR_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  store_narrow_unit_if #(.ADDR_W(ADDR_W)) bus ();

  store_narrow_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_beats  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    beat_t b;
    b.addr  = addr;
    b.wdata = wdata;
    b.be    = be;
    exp_q.push_back(b);
  endtask

  // Issue one request; returns #1 after the accepting edge with req_* scrambled.
  task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    int guard = 0;
    while (!bus.req_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got req_ready 0 for 50 cycles, expected 1");
    end
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_size  = size;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_data  = $urandom;
    bus.req_size  = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(bus.req_ready && !bus.mem_valid) && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy for 50 cycles, expected return to IDLE");
    end
  endtask

  // Monitor: a beat completes at the next posedge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && bus.mem_valid && bus.mem_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got beat at addr 0x%08h, expected no beat", bus.mem_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_addr",  bus.mem_addr,  mon_e.addr);
        check("beat_wdata", bus.mem_wdata, mon_e.wdata);
        check("beat_be",    {28'h0, bus.mem_be}, {28'h0, mon_e.be});
        n_beats++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = SZ_BYTE;
    bus.mem_ready = 1'b0;

    #1 rst_n = 1'b0;
    #3;
    check("rst_mem_valid", {31'h0, bus.mem_valid}, 32'h0);
    check("rst_err",       {31'h0, bus.err},       32'h0);
    check("rst_busy",      {31'h0, bus.busy},      32'h0);
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_mem_addr",  bus.mem_addr,           32'h0);
    check("rst_mem_wdata", bus.mem_wdata,          32'h0);
    check("rst_mem_be",    {28'h0, bus.mem_be},    32'h0);
    #8 rst_n = 1'b1;
    tick();

    // Byte store, single beat, ready returns the cycle after the beat completes.
    bus.mem_ready = 1'b1;
    push_beat(32'h0000_1000, 32'h00AB_0000, 4'b0100);
    issue(32'h0000_1002, 32'h0000_00AB, SZ_BYTE);
    check("sb_latency_valid", {31'h0, bus.mem_valid}, 32'h1);
    check("sb_ready_low",     {31'h0, bus.req_ready}, 32'h0);
    check("sb_busy",          {31'h0, bus.busy},      32'h1);
    tick();
    check("sb_ready_back",    {31'h0, bus.req_ready}, 32'h1);
    check("sb_valid_drop",    {31'h0, bus.mem_valid}, 32'h0);

    // Halfword crossing the word boundary.
    push_beat(32'h0000_1000, 32'hEF00_0000, 4'b1000);
    push_beat(32'h0000_1004, 32'h0000_00BE, 4'b0001);
    issue(32'h0000_1003, 32'h0000_BEEF, SZ_HALF);
    wait_idle();

    // Byte at top lane never splits; upper source bytes are discarded.
    push_beat(32'h0000_0000, 32'h7800_0000, 4'b1000);
    issue(32'h0000_0003, 32'h1234_5678, SZ_BYTE);
    wait_idle();

    // Aligned halfword with garbage in the upper half.
    push_beat(32'h0000_1000, 32'h0000_BEEF, 4'b0011);
    issue(32'h0000_1000, 32'hDEAD_BEEF, SZ_HALF);
    wait_idle();

    // Aligned word.
    push_beat(32'h0000_3000, 32'hCAFE_F00D, 4'b1111);
    issue(32'h0000_3000, 32'hCAFE_F00D, SZ_WORD);
    wait_idle();

    // Split word with beat 1 stalled for three cycles.
    bus.mem_ready = 1'b0;
    push_beat(32'h0000_2000, 32'h2233_4400, 4'b1110);
    push_beat(32'h0000_2004, 32'h0000_0011, 4'b0001);
    issue(32'h0000_2001, 32'h1122_3344, SZ_WORD);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'h0, bus.mem_valid}, 32'h1);
      check("stall_addr",  bus.mem_addr,           32'h0000_2000);
      check("stall_wdata", bus.mem_wdata,          32'h2233_4400);
      check("stall_be",    {28'h0, bus.mem_be},    32'h0000_000E);
      tick();
    end
    bus.mem_ready = 1'b1;
    wait_idle();

    // Split word wrapping past the top of the address space.
    push_beat(32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
    push_beat(32'h0000_0000, 32'h0000_1122, 4'b0011);
    issue(32'hFFFF_FFFE, 32'h1122_3344, SZ_WORD);
    wait_idle();

    // Illegal size: one-cycle err, no beat, still ready.
    issue(32'h0000_4000, 32'h5555_AAAA, 2'b11);
    check("ill_err",       {31'h0, bus.err},       32'h1);
    check("ill_mem_valid", {31'h0, bus.mem_valid}, 32'h0);
    check("ill_req_ready", {31'h0, bus.req_ready}, 32'h1);
    tick();
    check("ill_err_clear", {31'h0, bus.err},       32'h0);
    check("ill_no_beat",   {31'h0, bus.mem_valid}, 32'h0);

    // Reset during beat 1 of a split word discards both beats.
    bus.mem_ready = 1'b0;
    issue(32'h0000_5002, 32'hAABB_CCDD, SZ_WORD);
    check("rstmid_valid_pre", {31'h0, bus.mem_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid",     {31'h0, bus.mem_valid}, 32'h0);
    check("rstmid_ready",     {31'h0, bus.req_ready}, 32'h1);
    check("rstmid_busy",      {31'h0, bus.busy},      32'h0);
    check("rstmid_be",        {28'h0, bus.mem_be},    32'h0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstmid_no_beat2", {31'h0, bus.mem_valid}, 32'h0);
      check("rstmid_idle",     {31'h0, bus.busy},      32'h0);
    end

    // Normal operation after reset.
    push_beat(32'h0000_6000, 32'h0000_5A00, 4'b0010);
    issue(32'h0000_6001, 32'hFFFF_FF5A, SZ_BYTE);
    wait_idle();
    tick();

    check("queue_drained", exp_q.size(), 32'h0);
    check("beat_count",    n_beats,      32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
